threshold_ext: RTL and testbench

- Parametrised successor of the adaptive-threshold stage.
- Scans a WIDTH x HEIGHT image in raster order (column fastest). Reads pixel and local threshold from two synchronous ROMs and writes one result per pixel to the result memory.
- Adds over the previous generation: configurable data width, start handshake, signed offset, four output modes, and a pipelined one-pixel-per-clock scan.

---
 rtl/threshold_ext.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_threshold_ext.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_ext.sv
// -----------------------------------------------------------------------------
// threshold_ext
//
// Adaptive-threshold scanner. Walks a (2^WIDTH_BITS) x (2^HEIGHT_BITS) image in
// raster order (column fastest), reading one pixel and its local threshold per
// clock from two synchronous ROMs and writing one thresholded result per pixel
// to a result memory. The scan is a three-stage pipeline:
//   S0: address issued to both ROMs
//   S1: ROM data valid, threshold arithmetic and mode select
//   S2: registered write to the result memory
//
// Optional feature macro: THRESHOLD_EXT_STATS_EN
//   defined   -> oFgCount counts foreground pixels of the current scan
//   undefined -> oFgCount is tied to zero and no counter is built
//
// Ports:
//   clock           system clock, everything on the rising edge
//   reset           synchronous active-high reset, overrides everything
//   iStart          start request, honoured only in IDLE or DONE
//   iMode           output mode, latched on start:
//                     0 binary, 1 inverse binary, 2 truncate, 3 to-zero
//   iOffset         signed offset subtracted from threshold, latched on start
//   oImageCol/Row   image ROM address
//   iImageData      image ROM data, one cycle after the address
//   oThresholdCol/Row  threshold ROM address (always equal to image address)
//   iThresholdData  threshold ROM data, one cycle after the address
//   oResultCol/Row  result write address
//   oResultData     result write data, holds between writes
//   oResultWren     result write enable, one pulse per pixel
//   oBusy           high while scanning or draining the pipeline
//   finished        high in DONE until the next accepted start
//   oFgCount        foreground pixel count of the current scan
// -----------------------------------------------------------------------------
module threshold_ext #(
  parameter int WIDTH_BITS  = 7,
  parameter int HEIGHT_BITS = 7,
  parameter int DATA_BITS   = 8
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 iStart,
  input  logic [1:0]                           iMode,
  input  logic [DATA_BITS-1:0]                 iOffset,
  output logic [WIDTH_BITS-1:0]                oImageCol,
  output logic [HEIGHT_BITS-1:0]               oImageRow,
  input  logic [DATA_BITS-1:0]                 iImageData,
  output logic [WIDTH_BITS-1:0]                oThresholdCol,
  output logic [HEIGHT_BITS-1:0]               oThresholdRow,
  input  logic [DATA_BITS-1:0]                 iThresholdData,
  output logic [WIDTH_BITS-1:0]                oResultCol,
  output logic [HEIGHT_BITS-1:0]               oResultRow,
  output logic [DATA_BITS-1:0]                 oResultData,
  output logic                                 oResultWren,
  output logic                                 oBusy,
  output logic                                 finished,
  output logic [WIDTH_BITS+HEIGHT_BITS:0]      oFgCount
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] MODE_BINARY  = 2'd0;
  localparam logic [1:0] MODE_INVERSE = 2'd1;
  localparam logic [1:0] MODE_TRUNC   = 2'd2;
  localparam logic [1:0] MODE_TOZERO  = 2'd3;

  // Two guard bits are enough: thr is in [0, MAX] and -offset is in
  // [-(2^(D-1)-1), 2^(D-1)], so the difference never leaves D+2 signed range.
  localparam int EXT_BITS = DATA_BITS + 2;
  localparam int CNT_BITS = WIDTH_BITS + HEIGHT_BITS + 1;

  localparam logic [DATA_BITS-1:0]   DATA_MAX = '1;
  localparam logic [WIDTH_BITS-1:0]  COL_MAX  = '1;
  localparam logic [HEIGHT_BITS-1:0] ROW_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  logic [1:0]             state_q, state_d;
  logic [WIDTH_BITS-1:0]  col_q, col_d;
  logic [HEIGHT_BITS-1:0] row_q, row_d;
  logic [1:0]             mode_q;
  logic [DATA_BITS-1:0]   offset_q;

  logic                   valid1_q;
  logic [WIDTH_BITS-1:0]  col1_q;
  logic [HEIGHT_BITS-1:0] row1_q;

  logic                   wren_q;
  logic [WIDTH_BITS-1:0]  resCol_q;
  logic [HEIGHT_BITS-1:0] resRow_q;
  logic [DATA_BITS-1:0]   resData_q;

  logic                   startAccept;
  logic                   lastAddr;

  logic signed [EXT_BITS-1:0] thrExt;
  logic signed [EXT_BITS-1:0] offExt;
  logic signed [EXT_BITS-1:0] teffWide;
  logic [DATA_BITS-1:0]       teff;
  logic                       isFg;
  logic [DATA_BITS-1:0]       resultVal;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign startAccept = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && iStart;
  assign lastAddr    = (col_q == COL_MAX) && (row_q == ROW_MAX);

  // ---------------------------------------------------------------------------
  // Next-state and address counter logic. The counter holds on the last pixel
  // once the scan stops issuing, and is cleared on every accepted start.
  // DRAIN ends on the cycle where the final write is on the bus: S2 is
  // writing while S1 is already empty.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (iStart) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_RUN: begin
        if (lastAddr) begin
          state_d = ST_DRAIN;
        end else begin
          col_d = col_q + WIDTH_BITS'(1);
          if (col_q == COL_MAX) begin
            row_d = row_q + HEIGHT_BITS'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (wren_q && !valid1_q) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM and address registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan configuration is captured once per scan so the inputs may change
  // freely while the scan runs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= MODE_BINARY;
      offset_q <= '0;
    end else if (startAccept) begin
      mode_q   <= iMode;
      offset_q <= iOffset;
    end
  end

  // ---------------------------------------------------------------------------
  // S0 -> S1: remember which address the ROMs are fetching this cycle, so the
  // matching data can be tagged with its pixel position one cycle later.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      valid1_q <= 1'b0;
      col1_q   <= '0;
      row1_q   <= '0;
    end else begin
      valid1_q <= (state_q == ST_RUN);
      col1_q   <= col_q;
      row1_q   <= row_q;
    end
  end

  // ---------------------------------------------------------------------------
  // S1 arithmetic: effective threshold is the local threshold minus the signed
  // offset, clamped back into the pixel range. In the wide result the sign bit
  // flags an underflow and bit DATA_BITS flags a value above DATA_MAX.
  // ---------------------------------------------------------------------------
  assign thrExt   = signed'({2'b00, iThresholdData});
  assign offExt   = signed'({{2{offset_q[DATA_BITS-1]}}, offset_q});
  assign teffWide = thrExt - offExt;

  always_comb begin
    teff = teffWide[DATA_BITS-1:0];
    if (teffWide[EXT_BITS-1]) begin
      teff = '0;
    end else if (teffWide[DATA_BITS]) begin
      teff = DATA_MAX;
    end
  end

  assign isFg = (iImageData > teff);

  // ---------------------------------------------------------------------------
  // S1 mode select
  // ---------------------------------------------------------------------------
  always_comb begin
    resultVal = '0;
    case (mode_q)
      MODE_BINARY:  resultVal = isFg ? DATA_MAX : '0;
      MODE_INVERSE: resultVal = isFg ? '0 : DATA_MAX;
      MODE_TRUNC:   resultVal = isFg ? teff : iImageData;
      MODE_TOZERO:  resultVal = isFg ? iImageData : '0;
      default:      resultVal = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // S2: registered write port. Address and data only load on a real write so
  // that they hold their last value between writes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      wren_q    <= 1'b0;
      resCol_q  <= '0;
      resRow_q  <= '0;
      resData_q <= '0;
    end else begin
      wren_q <= valid1_q;
      if (valid1_q) begin
        resCol_q  <= col1_q;
        resRow_q  <= row1_q;
        resData_q <= resultVal;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Foreground statistics. The count is advanced at the same edge as the write
  // it belongs to, and saturates rather than wrapping.
  // ---------------------------------------------------------------------------
`ifdef THRESHOLD_EXT_STATS_EN
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  logic [CNT_BITS-1:0] fgCount_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      fgCount_q <= '0;
    end else if (startAccept) begin
      fgCount_q <= '0;
    end else if (valid1_q && isFg && (fgCount_q != CNT_MAX)) begin
      fgCount_q <= fgCount_q + CNT_BITS'(1);
    end
  end

  assign oFgCount = fgCount_q;
`else
  assign oFgCount = '0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign oImageCol     = col_q;
  assign oImageRow     = row_q;
  assign oThresholdCol = col_q;
  assign oThresholdRow = row_q;
  assign oResultCol    = resCol_q;
  assign oResultRow    = resRow_q;
  assign oResultData   = resData_q;
  assign oResultWren   = wren_q;
  assign oBusy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign finished      = (state_q == ST_DONE);

endmodule

// File: tb/tb_threshold_ext.sv
// -----------------------------------------------------------------------------
// tb_threshold_ext
//
// Bench for threshold_ext on a 4x4 image with 8-bit data. Two ROM models feed
// the design; each scan's expected writes come either from a fixed table entry
// or from a behavioural model that applies the thresholding rules with plain
// integer arithmetic, and are consumed in raster order as writes appear.
// -----------------------------------------------------------------------------
module tb_threshold_ext;

  localparam int WB = 2;
  localparam int HB = 2;
  localparam int DB = 8;
  localparam int NPIX = (1 << WB) * (1 << HB);

  logic            clock;
  logic            reset;
  logic            iStart;
  logic [1:0]      iMode;
  logic [DB-1:0]   iOffset;
  logic [WB-1:0]   oImageCol;
  logic [HB-1:0]   oImageRow;
  logic [DB-1:0]   iImageData;
  logic [WB-1:0]   oThresholdCol;
  logic [HB-1:0]   oThresholdRow;
  logic [DB-1:0]   iThresholdData;
  logic [WB-1:0]   oResultCol;
  logic [HB-1:0]   oResultRow;
  logic [DB-1:0]   oResultData;
  logic            oResultWren;
  logic            oBusy;
  logic            finished;
  logic [WB+HB:0]  oFgCount;

  logic [DB-1:0] imgMem [NPIX];
  logic [DB-1:0] thrMem [NPIX];

  int checks;
  int errors;

  typedef struct {
    int col;
    int row;
    int data;
  } write_t;

  write_t expQ[$];

  typedef struct {
    int pixel;
    int thr;
    int mode;
    int offset;
    int expData;
    int expFg;
  } vec_t;

  vec_t vecs[10];

  threshold_ext #(
    .WIDTH_BITS (WB),
    .HEIGHT_BITS(HB),
    .DATA_BITS  (DB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iStart        (iStart),
    .iMode         (iMode),
    .iOffset       (iOffset),
    .oImageCol     (oImageCol),
    .oImageRow     (oImageRow),
    .iImageData    (iImageData),
    .oThresholdCol (oThresholdCol),
    .oThresholdRow (oThresholdRow),
    .iThresholdData(iThresholdData),
    .oResultCol    (oResultCol),
    .oResultRow    (oResultRow),
    .oResultData   (oResultData),
    .oResultWren   (oResultWren),
    .oBusy         (oBusy),
    .finished      (finished),
    .oFgCount      (oFgCount)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Synchronous ROMs: data for the presented address appears after the edge.
  always @(posedge clock) begin
    iImageData     <= imgMem[{oImageRow, oImageCol}];
    iThresholdData <= thrMem[{oThresholdRow, oThresholdCol}];
  end

  // Hard stop in case something upstream blocks forever.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: effective threshold from the plain-integer rules.
  function automatic int refTeff(input int thr, input int offRaw);
    int off;
    int t;
    off = (offRaw >= 128) ? offRaw - 256 : offRaw;
    t = thr - off;
    if (t < 0) t = 0;
    if (t > 255) t = 255;
    return t;
  endfunction

  function automatic int refFg(input int pix, input int thr, input int offRaw);
    return (pix > refTeff(thr, offRaw)) ? 1 : 0;
  endfunction

  function automatic int refOut(input int pix, input int thr, input int mode, input int offRaw);
    int teff;
    int fg;
    teff = refTeff(thr, offRaw);
    fg = refFg(pix, thr, offRaw);
    case (mode)
      0: return (fg != 0) ? 255 : 0;
      1: return (fg != 0) ? 0 : 255;
      2: return (fg != 0) ? teff : pix;
      default: return (fg != 0) ? pix : 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Runs one scan and checks it. Called just after a falling edge; returns just
  // after a falling edge. fixedData >= 0 overrides the model for every pixel.
  task automatic applyStimulus(input int mode, input int offset, input int fixedData,
                               input int fixedFg, input bit holdStart, input bit pulseBusy,
                               input int resetAtWrite);
    int expFgTotal;
    int writes;
    int firstWr;
    int finN;
    int lastData;
    bit aborted;
    write_t w;

    expQ.delete();
    expFgTotal = 0;
    for (int r = 0; r < (1 << HB); r++) begin
      for (int c = 0; c < (1 << WB); c++) begin
        int idx;
        idx = r * (1 << WB) + c;
        w.col = c;
        w.row = r;
        if (fixedData >= 0) begin
          w.data = fixedData;
          expFgTotal += fixedFg;
        end else begin
          w.data = refOut(int'(imgMem[idx]), int'(thrMem[idx]), mode, offset);
          expFgTotal += refFg(int'(imgMem[idx]), int'(thrMem[idx]), offset);
        end
        expQ.push_back(w);
      end
    end
`ifndef THRESHOLD_EXT_STATS_EN
    expFgTotal = 0;
`endif

    iMode   = 2'(mode);
    iOffset = 8'(offset);
    iStart  = 1'b1;
    @(posedge clock);
    #1;
    if (!holdStart) iStart = 1'b0;
    // Scrambling the config inputs after accept exercises the latching.
    iMode   = 2'($urandom_range(0, 3));
    iOffset = 8'($urandom_range(0, 255));

    writes   = 0;
    firstWr  = -1;
    finN     = -1;
    lastData = 0;
    aborted  = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) begin
        checkOutput("busyAfterAccept", int'(oBusy), 1);
        checkOutput("finishedDropOnAccept", int'(finished), 0);
        checkOutput("fgClearedOnStart", int'(oFgCount), 0);
      end
      if (pulseBusy) begin
        if (n == 5) iStart = 1'b1;
        else if (n == 6) iStart = 1'b0;
      end
      checkOutput("romColEqual", int'(oImageCol), int'(oThresholdCol));
      checkOutput("romRowEqual", int'(oImageRow), int'(oThresholdRow));
      if (oResultWren) begin
        writes++;
        if (firstWr < 0) firstWr = n;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWrite", 1, 0);
        end else begin
          w = expQ.pop_front();
          checkOutput("writeCol", int'(oResultCol), w.col);
          checkOutput("writeRow", int'(oResultRow), w.row);
          checkOutput("writeData", int'(oResultData), w.data);
        end
        lastData = int'(oResultData);
        if (resetAtWrite > 0 && writes == resetAtWrite) begin
          aborted = 1'b1;
          break;
        end
      end else if (writes > 0) begin
        checkOutput("dataHold", int'(oResultData), lastData);
      end
      if (finished) begin
        finN = n;
        break;
      end
    end

    if (aborted) begin
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
        checkOutput("wrenAfterReset", int'(oResultWren), 0);
        checkOutput("finishedAfterReset", int'(finished), 0);
        checkOutput("busyAfterReset", int'(oBusy), 0);
        @(negedge clock);
      end
    end else begin
      checkOutput("finishedSeen", (finN >= 0) ? 1 : 0, 1);
      checkOutput("firstWriteCycle", firstWr, 3);
      checkOutput("finishedCycle", finN, 19);
      checkOutput("writeCount", writes, NPIX);
      checkOutput("pendingWrites", expQ.size(), 0);
      checkOutput("busyAtDone", int'(oBusy), 0);
      checkOutput("wrenAtDone", int'(oResultWren), 0);
      checkOutput("fgCount", int'(oFgCount), expFgTotal);
    end
  endtask

  task automatic fillConst(input int pix, input int thr);
    for (int i = 0; i < NPIX; i++) begin
      imgMem[i] = 8'(pix);
      thrMem[i] = 8'(thr);
    end
  endtask

  task automatic fillRandom();
    for (int i = 0; i < NPIX; i++) begin
      imgMem[i] = 8'($urandom_range(0, 255));
      thrMem[i] = 8'($urandom_range(0, 255));
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b1;
    iStart  = 1'b0;
    iMode   = 2'd0;
    iOffset = 8'd0;
    fillConst(0, 0);

    // Table of single-value scans: pixel, thr, mode, offset, data, fg per pixel.
    vecs[0] = '{pixel: 100, thr: 100, mode: 0, offset: 0,    expData: 0,   expFg: 0};
    vecs[1] = '{pixel: 100, thr: 100, mode: 0, offset: 1,    expData: 255, expFg: 1};
    vecs[2] = '{pixel: 200, thr: 5,   mode: 2, offset: 128,  expData: 133, expFg: 1};
    vecs[3] = '{pixel: 255, thr: 250, mode: 1, offset: 236,  expData: 255, expFg: 0};
    vecs[4] = '{pixel: 0,   thr: 10,  mode: 1, offset: 50,   expData: 255, expFg: 0};
    vecs[5] = '{pixel: 1,   thr: 10,  mode: 0, offset: 50,   expData: 255, expFg: 1};
    vecs[6] = '{pixel: 30,  thr: 40,  mode: 2, offset: 0,    expData: 30,  expFg: 0};
    vecs[7] = '{pixel: 50,  thr: 40,  mode: 3, offset: 0,    expData: 50,  expFg: 1};
    vecs[8] = '{pixel: 255, thr: 0,   mode: 3, offset: 127,  expData: 255, expFg: 1};
    vecs[9] = '{pixel: 41,  thr: 40,  mode: 2, offset: 1,    expData: 39,  expFg: 1};

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rstImageCol", int'(oImageCol), 0);
    checkOutput("rstImageRow", int'(oImageRow), 0);
    checkOutput("rstThrCol", int'(oThresholdCol), 0);
    checkOutput("rstThrRow", int'(oThresholdRow), 0);
    checkOutput("rstResCol", int'(oResultCol), 0);
    checkOutput("rstResRow", int'(oResultRow), 0);
    checkOutput("rstResData", int'(oResultData), 0);
    checkOutput("rstWren", int'(oResultWren), 0);
    checkOutput("rstBusy", int'(oBusy), 0);
    checkOutput("rstFinished", int'(finished), 0);
    checkOutput("rstFgCount", int'(oFgCount), 0);

    $display("[TB] table-driven scans");
    for (int v = 0; v < 10; v++) begin
      fillConst(vecs[v].pixel, vecs[v].thr);
      applyStimulus(vecs[v].mode, vecs[v].offset, vecs[v].expData, vecs[v].expFg, 1'b0, 1'b0, 0);
    end

    $display("[TB] gradient image, to-zero mode");
    for (int r = 0; r < (1 << HB); r++) begin
      for (int c = 0; c < (1 << WB); c++) begin
        imgMem[r * (1 << WB) + c] = 8'(c * 16 + r);
        thrMem[r * (1 << WB) + c] = 8'd20;
      end
    end
    applyStimulus(3, 0, -1, 0, 1'b0, 1'b0, 0);

    $display("[TB] reset during 7th write, then restart");
    fillRandom();
    applyStimulus(0, 0, -1, 0, 1'b0, 1'b0, 7);
    applyStimulus(2, 3, -1, 0, 1'b0, 1'b0, 0);

    $display("[TB] start pulse while busy");
    fillRandom();
    applyStimulus(1, 250, -1, 0, 1'b0, 1'b1, 0);

    $display("[TB] start held high across DONE");
    fillRandom();
    applyStimulus(0, 5, -1, 0, 1'b1, 1'b0, 0);
    applyStimulus(3, 200, -1, 0, 1'b0, 1'b0, 0);

    $display("[TB] randomized scans");
    for (int t = 0; t < 8; t++) begin
      fillRandom();
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), -1, 0,
                    1'b0, 1'b0, 0);
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
